// File: rtl/ped_phase_scheduler.sv
// Pedestrian crossing phase scheduler for a 4-way intersection: latches button
// requests, grants them round-robin, and runs WALK then all-stop CLEAR per phase.
module ped_phase_scheduler #(
  parameter int WALK_TIME  = 20,
  parameter int CLEAR_TIME = 3
) (
  input  logic       CLK_1Hz,
  input  logic       RST,
  input  logic [3:0] Ped_req,
  input  logic       Light_out_time,
  output logic [1:0] Signal_pos,
  output logic [4:0] Ped_signal_time,
  output logic [3:0] Ped_ack,
  output logic       Ped_busy,
  output logic [3:0] Pend_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t     r_state, w_nextState;
  logic [1:0] r_signalPos, w_nextSignalPos;
  logic [4:0] r_time, w_nextTime;
  logic [3:0] r_ack, w_nextAck;
  logic       r_busy, w_nextBusy;
  logic [3:0] r_pending, w_nextPending;
  logic [1:0] r_lastGrant, w_nextLastGrant;
  logic [3:0] r_clrCnt, w_nextClrCnt;

  logic [1:0] w_grant;
  logic       w_grantValid;
  logic [3:0] w_activeMask;

  // Round-robin search starting just after the previously granted direction.
  always_comb begin
    w_grant      = 2'd0;
    w_grantValid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_grantValid && r_pending[r_lastGrant + 2'(k)]) begin
        w_grant      = r_lastGrant + 2'(k);
        w_grantValid = 1'b1;
      end
    end
  end

  assign w_activeMask = (r_state != IDLE) ? (4'b0001 << r_signalPos) : 4'b0000;

  always_comb begin
    w_nextState     = r_state;
    w_nextSignalPos = r_signalPos;
    w_nextTime      = r_time;
    w_nextAck       = 4'b0000;
    w_nextBusy      = r_busy;
    w_nextPending   = r_pending;
    w_nextLastGrant = r_lastGrant;
    w_nextClrCnt    = r_clrCnt;

    if (Light_out_time) begin
      w_nextState   = IDLE;
      w_nextTime    = 5'd0;
      w_nextBusy    = 1'b0;
      w_nextPending = 4'b0000;
    end else begin
      w_nextPending = r_pending | (Ped_req & ~w_activeMask);
      case (r_state)
        IDLE: begin
          w_nextTime = 5'd0;
          if (w_grantValid) begin
            w_nextState              = WALK;
            w_nextSignalPos          = w_grant;
            w_nextTime               = 5'(WALK_TIME);
            w_nextLastGrant          = w_grant;
            w_nextPending[w_grant]   = 1'b0;
            w_nextAck                = 4'b0001 << w_grant;
            w_nextBusy               = 1'b1;
          end
        end
        WALK: begin
          if (r_time > 5'd1) begin
            w_nextTime = r_time - 5'd1;
          end else begin
            w_nextTime   = 5'd0;
            w_nextState  = CLEAR;
            w_nextClrCnt = 4'(CLEAR_TIME);
          end
        end
        CLEAR: begin
          w_nextTime = 5'd0;
          if (r_clrCnt <= 4'd1) begin
            w_nextState  = IDLE;
            w_nextBusy   = 1'b0;
            w_nextClrCnt = 4'd0;
          end else begin
            w_nextClrCnt = r_clrCnt - 4'd1;
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextTime  = 5'd0;
          w_nextBusy  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_1Hz or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_signalPos <= 2'd0;
      r_time      <= 5'd0;
      r_ack       <= 4'b0000;
      r_busy      <= 1'b0;
      r_pending   <= 4'b0000;
      r_lastGrant <= 2'd3;
      r_clrCnt    <= 4'd0;
    end else begin
      r_state     <= w_nextState;
      r_signalPos <= w_nextSignalPos;
      r_time      <= w_nextTime;
      r_ack       <= w_nextAck;
      r_busy      <= w_nextBusy;
      r_pending   <= w_nextPending;
      r_lastGrant <= w_nextLastGrant;
      r_clrCnt    <= w_nextClrCnt;
    end
  end

  assign Signal_pos      = r_signalPos;
  assign Ped_signal_time = r_time;
  assign Ped_ack         = r_ack;
  assign Ped_busy        = r_busy;
  assign Pend_out        = r_pending;

endmodule

// File: tb/tb_ped_phase_scheduler.sv
// Self-checking bench for ped_phase_scheduler: an elapsed-time phase model is
// compared every cycle, with directed scenarios pinning literal expectations.
module tb_ped_phase_scheduler;

  localparam int WT = 20;
  localparam int CT = 3;

  logic       CLK_1Hz;
  logic       RST;
  logic [3:0] Ped_req;
  logic       Light_out_time;
  logic [1:0] Signal_pos;
  logic [4:0] Ped_signal_time;
  logic [3:0] Ped_ack;
  logic       Ped_busy;
  logic [3:0] Pend_out;

  int testsRun  = 0;
  int failCount = 0;

  ped_phase_scheduler #(.WALK_TIME(WT), .CLEAR_TIME(CT)) dut (
    .CLK_1Hz(CLK_1Hz),
    .RST(RST),
    .Ped_req(Ped_req),
    .Light_out_time(Light_out_time),
    .Signal_pos(Signal_pos),
    .Ped_signal_time(Ped_signal_time),
    .Ped_ack(Ped_ack),
    .Ped_busy(Ped_busy),
    .Pend_out(Pend_out)
  );

  initial CLK_1Hz = 1'b0;
  always #5 CLK_1Hz = ~CLK_1Hz;

  // Model: a phase is "active" for WT+CT edges after its grant; walk time is
  // derived from edges elapsed since the grant.
  logic [3:0] mPend;
  int         mLast;
  int         mPos;
  bit         mActive;
  int         mElapsed;
  logic [3:0] mAck;

  task automatic modelStep(input logic [3:0] req, input logic lo);
    int  g;
    bit  found;
    bit  wasActive;
    found     = 0;
    g         = 0;
    wasActive = mActive;
    mAck      = 4'b0000;
    if (lo) begin
      mActive = 0;
      mPend   = 4'b0000;
    end else begin
      if (!wasActive) begin
        for (int k = 1; k <= 4; k++) begin
          if (!found && mPend[(mLast + k) % 4]) begin
            g     = (mLast + k) % 4;
            found = 1;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !(wasActive && i == mPos)) mPend[i] = 1'b1;
      end
      if (wasActive) begin
        mElapsed++;
        if (mElapsed >= WT + CT) mActive = 0;
      end else if (found) begin
        mActive  = 1;
        mElapsed = 0;
        mPos     = g;
        mLast    = g;
        mPend[g] = 1'b0;
        mAck[g]  = 1'b1;
      end
    end
  endtask

  always @(posedge CLK_1Hz or posedge RST) begin
    if (RST) begin
      mPend    = 4'b0000;
      mLast    = 3;
      mPos     = 0;
      mActive  = 0;
      mElapsed = 0;
      mAck     = 4'b0000;
    end else begin
      modelStep(Ped_req, Light_out_time);
    end
  end

  function automatic int expTime();
    return (mActive && mElapsed < WT) ? (WT - mElapsed) : 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic lo);
    Ped_req        = req;
    Light_out_time = lo;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK_1Hz);
  endtask

  task automatic doReset();
    RST = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    tick(2);
    RST = 1'b0;
    tick(1);
  endtask

  always @(negedge CLK_1Hz) begin
    checkOutput("model_pos",  int'(Signal_pos),      mPos);
    checkOutput("model_time", int'(Ped_signal_time), expTime());
    checkOutput("model_ack",  int'(Ped_ack),         int'(mAck));
    checkOutput("model_busy", int'(Ped_busy),        int'(mActive));
    checkOutput("model_pend", int'(Pend_out),        int'(mPend));
  end

  initial begin
    logic [3:0] ackQ[$];
    logic [1:0] posQ[$];
    int         loHold;
    logic [3:0] r;

    RST = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    tick(1);
    checkOutput("reset_pos",  int'(Signal_pos), 0);
    checkOutput("reset_time", int'(Ped_signal_time), 0);
    checkOutput("reset_busy", int'(Ped_busy), 0);
    checkOutput("reset_pend", int'(Pend_out), 0);
    RST = 1'b0;
    tick(1);

    // Single request on direction 2
    applyStimulus(4'b0100, 1'b0);
    tick(1);
    checkOutput("single_pend", int'(Pend_out), 4'b0100);
    applyStimulus(4'b0000, 1'b0);
    tick(1);
    checkOutput("single_pos",  int'(Signal_pos), 2);
    checkOutput("single_time", int'(Ped_signal_time), 20);
    checkOutput("single_ack",  int'(Ped_ack), 4'b0100);
    checkOutput("single_busy", int'(Ped_busy), 1);
    tick(1);
    checkOutput("single_ack_drop", int'(Ped_ack), 0);
    checkOutput("single_time19", int'(Ped_signal_time), 19);
    tick(18);
    checkOutput("single_time1", int'(Ped_signal_time), 1);
    tick(1);
    checkOutput("single_time0", int'(Ped_signal_time), 0);
    tick(2);
    checkOutput("single_busy_clear", int'(Ped_busy), 1);
    tick(1);
    checkOutput("single_busy_end", int'(Ped_busy), 0);

    // Simultaneous requests on all directions
    doReset();
    applyStimulus(4'b1111, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    for (int c = 0; c < 100; c++) begin
      tick(1);
      if (Ped_ack != 4'b0000) begin
        ackQ.push_back(Ped_ack);
        posQ.push_back(Signal_pos);
      end
    end
    checkOutput("simul_ack_count", ackQ.size(), 4);
    for (int i = 0; i < 4 && i < ackQ.size(); i++) begin
      checkOutput("simul_ack_onehot", int'(ackQ[i]), 1 << i);
      checkOutput("simul_pos_order",  int'(posQ[i]), i);
    end

    // Round-robin: after direction 1, direction 2 beats direction 0
    doReset();
    applyStimulus(4'b0010, 1'b0);
    tick(1);
    applyStimulus(4'b0101, 1'b0);
    tick(1);
    checkOutput("rr_first_ack", int'(Ped_ack), 4'b0010);
    applyStimulus(4'b0000, 1'b0);
    tick(23);
    checkOutput("rr_idle", int'(Ped_busy), 0);
    tick(1);
    checkOutput("rr_second_ack", int'(Ped_ack), 4'b0100);
    checkOutput("rr_second_pos", int'(Signal_pos), 2);

    // Lights-out mid-walk
    doReset();
    applyStimulus(4'b0001, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    tick(1);
    applyStimulus(4'b1000, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    tick(9);
    checkOutput("lo_pre_time", int'(Ped_signal_time), 10);
    checkOutput("lo_pre_pend", int'(Pend_out), 4'b1000);
    applyStimulus(4'b1111, 1'b1);
    tick(1);
    checkOutput("lo_time", int'(Ped_signal_time), 0);
    checkOutput("lo_busy", int'(Ped_busy), 0);
    checkOutput("lo_pend", int'(Pend_out), 0);
    tick(5);
    checkOutput("lo_hold_pend", int'(Pend_out), 0);
    checkOutput("lo_hold_pos", int'(Signal_pos), 0);
    applyStimulus(4'b1111, 1'b0);
    tick(1);
    checkOutput("lo_release_noack", int'(Ped_ack), 0);
    tick(1);
    checkOutput("lo_release_ack", int'(Ped_ack), 4'b0010);
    applyStimulus(4'b0000, 1'b0);
    tick(80);

    // Request for the active direction is ignored
    doReset();
    applyStimulus(4'b1000, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    tick(1);
    checkOutput("active_pos", int'(Signal_pos), 3);
    applyStimulus(4'b1001, 1'b0);
    tick(1);
    checkOutput("active_pend", int'(Pend_out), 4'b0001);
    applyStimulus(4'b0000, 1'b0);
    tick(22);
    checkOutput("active_idle", int'(Ped_busy), 0);
    tick(1);
    checkOutput("active_next_ack", int'(Ped_ack), 4'b0001);
    checkOutput("active_next_pos", int'(Signal_pos), 0);
    tick(30);

    // Async reset during CLEAR
    applyStimulus(4'b0100, 1'b0);
    tick(1);
    applyStimulus(4'b0010, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    tick(21);
    checkOutput("arst_in_clear", int'(Ped_busy), 1);
    #2 RST = 1'b1;
    #1;
    checkOutput("arst_pos",  int'(Signal_pos), 0);
    checkOutput("arst_time", int'(Ped_signal_time), 0);
    checkOutput("arst_ack",  int'(Ped_ack), 0);
    checkOutput("arst_busy", int'(Ped_busy), 0);
    checkOutput("arst_pend", int'(Pend_out), 0);
    tick(2);
    RST = 1'b0;
    tick(5);
    checkOutput("arst_no_grant", int'(Ped_busy), 0);

    // Randomized traffic
    loHold = 0;
    for (int c = 0; c < 1500; c++) begin
      r = 4'($urandom_range(0, 15));
      if (loHold > 0) begin
        loHold--;
        applyStimulus(r, 1'b1);
      end else begin
        if ($urandom_range(0, 79) == 0) loHold = $urandom_range(1, 6);
        applyStimulus(($urandom_range(0, 5) == 0) ? r : 4'b0000, 1'b0);
      end
      if ($urandom_range(0, 299) == 0) begin
        #3 RST = 1'b1;
        #1 checkOutput("rand_arst_busy", int'(Ped_busy), 0);
        tick(1);
        RST = 1'b0;
      end else begin
        tick(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
